stream_take_sum: RTL and testbench

//  Downstream consumer for int->stream producers (e.g. repeat_int). Accepts a

---
 rtl/stream_take_sum_pkg.sv | 15 +
 rtl/stream_take_sum.sv | 97 +++++++++
 tb/tb_stream_take_sum.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/stream_take_sum_pkg.sv
// Shared definitions for the stream_take_sum block: default widths and the
// 2-bit state encoding of the collect FSM.
package stream_take_sum_pkg;

    // Default data width (matches the 8-bit int type used by stream producers)
    localparam int STS_WIDTH_DEF = 8;
    // Default width of the element-count command
    localparam int STS_CNT_W_DEF = 8;

    // FSM state encoding
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_COLLECT = 2'd1;
    localparam logic [1:0] ST_DONE    = 2'd2;

endpackage

// File: rtl/stream_take_sum.sv
// stream_take_sum: accepts a count command, drains exactly that many elements
// from a valid/ready stream and presents their wrapped two's-complement sum
// as a single result with valid/ready handshake. Terminates the stream.
module stream_take_sum
    import stream_take_sum_pkg::*;
#(
    parameter int WIDTH = STS_WIDTH_DEF,
    parameter int CNT_W = STS_CNT_W_DEF
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [CNT_W-1:0] dN,
    input  logic [WIDTH-1:0] sIn,
    input  logic             sIn_valid,
    output logic             sIn_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] dOut
);

    logic [1:0]              state;
    logic signed [WIDTH-1:0] acc;
    logic [CNT_W-1:0]        remaining;
    logic signed [WIDTH-1:0] sum_next;

    // Modulo-2^WIDTH addition: the sum wraps silently, no saturation or flag.
    function automatic logic signed [WIDTH-1:0] wrap_add(
        input logic signed [WIDTH-1:0] a,
        input logic signed [WIDTH-1:0] b
    );
        return a + b;
    endfunction

    // Running sum including the element currently on the stream input
    always_comb begin
        sum_next = wrap_add(acc, $signed(sIn));
    end

    // Handshake flags decode straight from the state register, so there is
    // no combinational path from any valid input to any ready output.
    always_comb begin
        in_ready  = (state == ST_IDLE);
        sIn_ready = (state == ST_COLLECT);
        out_valid = (state == ST_DONE);
    end

    // FSM, accumulator and down-counter; reset discards any partial sum or
    // pending result.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state     <= ST_IDLE;
            acc       <= '0;
            remaining <= '0;
            dOut      <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        acc       <= '0;
                        remaining <= dN;
                        if (dN == '0) begin
                            dOut  <= '0;
                            state <= ST_DONE;
                        end else begin
                            state <= ST_COLLECT;
                        end
                    end
                end
                ST_COLLECT: begin
                    // remaining is at least 1 here, so the decrement never
                    // underflows even for the largest count
                    if (sIn_valid) begin
                        acc       <= sum_next;
                        remaining <= remaining - CNT_W'(1);
                        if (remaining == CNT_W'(1)) begin
                            dOut  <= sum_next;
                            state <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    // New command only accepted from IDLE, i.e. the cycle after
                    // the result handshake.
                    if (out_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_stream_take_sum.sv
// Testbench for stream_take_sum: directed scenarios with literal expected sums
// plus randomized transactions, all checked by a transaction-level model.
module tb_stream_take_sum;

    localparam int WIDTH = 8;
    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             nrst = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [CNT_W-1:0] dN = '0;
    logic [WIDTH-1:0] sIn = '0;
    logic             sIn_valid = 1'b0;
    logic             sIn_ready;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] dOut;

    always #5 clk = ~clk;

    stream_take_sum #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .nrst      (nrst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .dN        (dN),
        .sIn       (sIn),
        .sIn_valid (sIn_valid),
        .sIn_ready (sIn_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .dOut      (dOut)
    );

    int errors = 0;
    int checks = 0;

    logic [WIDTH-1:0] arr [0:255];

    // Transaction-level model: a command opens a job of N elements; the job's
    // result is the sum of the elements handed over, modulo 256.
    bit               m_busy = 0;
    bit               m_has  = 0;
    int               m_need = 0;
    logic [WIDTH-1:0] m_sum  = '0;
    logic [WIDTH-1:0] m_res  = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, sampled mid-cycle.
    always @(negedge clk) begin
        bit idle;
        if (!nrst) begin
            chk("rst_out_valid", 32'(out_valid), 32'd0);
            chk("rst_sIn_ready", 32'(sIn_ready), 32'd0);
            chk("rst_dOut", 32'(dOut), 32'd0);
            chk("rst_in_ready", 32'(in_ready), 32'd1);
            m_busy = 0;
            m_has  = 0;
            m_need = 0;
            m_sum  = '0;
        end else begin
            idle = !m_busy && !m_has;
            chk("mon_in_ready", 32'(in_ready), 32'(idle));
            chk("mon_sIn_ready", 32'(sIn_ready), 32'(m_busy));
            chk("mon_out_valid", 32'(out_valid), 32'(m_has));
            if (m_has) chk("mon_dOut", 32'(dOut), 32'(m_res));
            if (idle && in_valid) begin
                if (dN == 0) begin
                    m_has = 1;
                    m_res = '0;
                end else begin
                    m_busy = 1;
                    m_need = int'(dN);
                    m_sum  = '0;
                end
            end else if (m_busy && sIn_valid) begin
                m_sum  = m_sum + sIn;
                m_need = m_need - 1;
                if (m_need == 0) begin
                    m_busy = 0;
                    m_has  = 1;
                    m_res  = m_sum;
                end
            end else if (m_has && out_ready) begin
                m_has = 0;
            end
        end
    end

    task automatic send_cmd(input int n);
        int  cyc = 0;
        bit  done = 0;
        in_valid = 1'b1;
        dN = CNT_W'(n);
        while (!done && cyc < 200) begin
            @(negedge clk);
            done = in_ready;
            @(posedge clk);
            #1;
            cyc++;
        end
        in_valid = 1'b0;
        if (!done) chk("cmd_timeout", 32'd0, 32'd1);
    endtask

    // mode 0: back-to-back, 3: valid one cycle in three, -1: random valid
    task automatic drive_stream(input int n, input int mode);
        int idx = 0;
        int cyc = 0;
        bit take;
        while (idx < n && cyc < 5000) begin
            sIn = arr[idx];
            if (mode == 0)      sIn_valid = 1'b1;
            else if (mode > 0)  sIn_valid = ((cyc % mode) == 0);
            else                sIn_valid = 1'($urandom_range(0, 1));
            @(negedge clk);
            take = sIn_valid && sIn_ready;
            @(posedge clk);
            #1;
            if (take) idx++;
            cyc++;
        end
        sIn_valid = 1'b0;
        if (idx < n) chk("stream_timeout", 32'(idx), 32'(n));
    endtask

    // Result must already be valid (one cycle after final beat / command);
    // it is then held for 'hold' cycles with stream traffic offered.
    task automatic take_result(input logic [WIDTH-1:0] exp, input string name, input int hold);
        chk({name, "_latency"}, 32'(out_valid), 32'd1);
        chk({name, "_dOut"}, 32'(dOut), 32'(exp));
        chk({name, "_in_ready"}, 32'(in_ready), 32'd0);
        for (int i = 0; i < hold; i++) begin
            sIn_valid = 1'b1;
            sIn = 8'($urandom);
            @(negedge clk);
            chk({name, "_hold_valid"}, 32'(out_valid), 32'd1);
            chk({name, "_hold_dOut"}, 32'(dOut), 32'(exp));
            chk({name, "_hold_sIn_ready"}, 32'(sIn_ready), 32'd0);
            @(posedge clk);
            #1;
        end
        sIn_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk({name, "_drop"}, 32'(out_valid), 32'd0);
        chk({name, "_idle"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        int n;
        int mode;
        logic [WIDTH-1:0] exp;

        repeat (2) @(posedge clk);
        #1;
        nrst = 1'b1;
        @(posedge clk);
        #1;

        // 3 x 42 back-to-back
        for (int i = 0; i < 3; i++) arr[i] = 8'd42;
        send_cmd(3);
        drive_stream(3, 0);
        take_result(8'd126, "t1", 0);

        // zero-length command, stream offered but never consumed
        sIn_valid = 1'b1;
        sIn = 8'h55;
        send_cmd(0);
        take_result(8'd0, "t2", 1);

        // 4 x 100 wraps to 144, held 5 cycles
        for (int i = 0; i < 4; i++) arr[i] = 8'd100;
        send_cmd(4);
        drive_stream(4, 0);
        take_result(8'd144, "t3", 5);

        // -5 + 3, back-to-back then gapped
        arr[0] = 8'hFB;
        arr[1] = 8'h03;
        send_cmd(2);
        drive_stream(2, 0);
        take_result(8'hFE, "t4a", 0);
        send_cmd(2);
        drive_stream(2, 3);
        take_result(8'hFE, "t4b", 2);

        // reset after 2 of 3 beats discards the partial sum
        arr[0] = 8'd11;
        arr[1] = 8'd22;
        arr[2] = 8'd33;
        send_cmd(3);
        drive_stream(2, 0);
        nrst = 1'b0;
        @(negedge clk);
        @(posedge clk);
        #1;
        nrst = 1'b1;
        arr[0] = 8'd7;
        send_cmd(1);
        drive_stream(1, 0);
        take_result(8'd7, "t6", 0);

        // randomized transactions, including the maximum count
        for (int t = 0; t < 40; t++) begin
            if (t == 20)                          n = 255;
            else if ($urandom_range(0, 7) == 0)   n = 0;
            else                                  n = int'($urandom_range(1, 12));
            exp = '0;
            for (int i = 0; i < n; i++) begin
                arr[i] = 8'($urandom);
                exp = exp + arr[i];
            end
            case ($urandom_range(0, 2))
                0:       mode = 0;
                1:       mode = 3;
                default: mode = -1;
            endcase
            send_cmd(n);
            drive_stream(n, mode);
            take_result(exp, "rnd", int'($urandom_range(0, 3)));
        end

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
